// File: rtl/lzd.sv
// Lowest-index detector: one-hot of the first set bit (or first clear bit when
// DETECT_ZERO=1), scanning from bit 0 upward. All-zero result when none found.
module lzd #(
  parameter int W           = 16,
  parameter bit DETECT_ZERO = 1'b0
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot
);

  logic [W-1:0] x;

  assign x      = DETECT_ZERO ? ~vec : vec;
  // Two's-complement isolate-lowest-set-bit trick.
  assign onehot = x & (~x + W'(1));

endmodule

// File: rtl/onehot_enc.sv
// One-hot to binary encoder; all-zero input encodes to 0. Shared by lzd consumers.
module onehot_enc #(
  parameter  int W   = 16,
  localparam int IDW = $clog2(W)
) (
  input  logic [W-1:0]   onehot,
  output logic [IDW-1:0] id
);

  always_comb begin
    id = '0;
    for (int k = 0; k < W; k++)
      if (onehot[k]) id = id | IDW'(k);
  end

endmodule

// File: rtl/slot_alloc.sv
// Free-slot allocator: grants the lowest-index free slot via valid/ready and
// takes slots back on a free port, flagging double/out-of-range frees.
module slot_alloc #(
  parameter  int N   = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_alloc_vld,
  output logic           o_alloc_rdy,
  output logic [IDW-1:0] o_alloc_id,
  input  logic           i_free_vld,
  input  logic [IDW-1:0] i_free_id,
  output logic [N-1:0]   o_busy,
  output logic [IDW:0]   o_cnt,
  output logic           o_empty,
  output logic           o_full,
  output logic           o_err
);

  localparam int PADW = 2 ** IDW;
  localparam int CNTW = IDW + 1;

  logic [N-1:0]    busy, busy_nxt;
  logic [IDW:0]    cnt, cnt_nxt;
  logic            full, full_nxt;
  logic            err, err_nxt;

  logic [N-1:0]    first_free;
  logic [PADW-1:0] busy_ext;
  logic [PADW-1:0] free_dec;
  logic [N-1:0]    free_mask;
  logic            alloc_fire, free_fire, free_bad;

  lzd #(.W(N), .DETECT_ZERO(1'b1)) u_lzd (
    .vec    (busy),
    .onehot (first_free)
  );

  onehot_enc #(.W(N)) u_enc (
    .onehot (first_free),
    .id     (o_alloc_id)
  );

  // Zero-padding to a power of two makes out-of-range IDs read as "not busy",
  // so range and double-free checks collapse into a single lookup.
  always_comb begin
    busy_ext         = '0;
    busy_ext[N-1:0]  = busy;
  end

  assign free_dec   = PADW'(1) << i_free_id;
  assign free_mask  = free_dec[N-1:0];

  assign alloc_fire = i_alloc_vld && !full;
  assign free_fire  = i_free_vld && busy_ext[i_free_id];
  assign free_bad   = i_free_vld && !busy_ext[i_free_id];

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = cnt;
    err_nxt  = err;
    if (alloc_fire) busy_nxt = busy_nxt | first_free;
    if (free_fire)  busy_nxt = busy_nxt & ~free_mask;
    case ({alloc_fire, free_fire})
      2'b10:   cnt_nxt = cnt + CNTW'(1);
      2'b01:   cnt_nxt = cnt - CNTW'(1);
      default: cnt_nxt = cnt;
    endcase
    full_nxt = (cnt_nxt == CNTW'(N));
    if (free_bad) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
      full <= 1'b0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
      full <= full_nxt;
      err  <= err_nxt;
    end
  end

  assign o_alloc_rdy = !full;
  assign o_busy      = busy;
  assign o_cnt       = cnt;
  assign o_empty     = (cnt == '0);
  assign o_full      = full;
  assign o_err       = err;

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc (N=16): grants, full/free, simultaneous ops,
// double free and reset priority.
module tb_slot_alloc;

  localparam int N   = 16;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic           i_alloc_vld;
  logic           o_alloc_rdy;
  logic [IDW-1:0] o_alloc_id;
  logic           i_free_vld;
  logic [IDW-1:0] i_free_id;
  logic [N-1:0]   o_busy;
  logic [IDW:0]   o_cnt;
  logic           o_empty, o_full, o_err;

  int tests = 0;
  int fails = 0;

  slot_alloc #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_alloc_vld (i_alloc_vld),
    .o_alloc_rdy (o_alloc_rdy),
    .o_alloc_id  (o_alloc_id),
    .i_free_vld  (i_free_vld),
    .i_free_id   (i_free_id),
    .o_busy      (o_busy),
    .o_cnt       (o_cnt),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_alloc_vld = 1'b0; i_free_vld = 1'b0; i_free_id = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_alloc_vld = 1'b0; i_free_vld = 1'b0; i_free_id = '0;
    #2;
    do_reset();

    // reset values
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_cnt",   32'(o_cnt), 0);
    chk("rst_rdy",   32'(o_alloc_rdy), 1);
    chk("rst_id",    32'(o_alloc_id), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full",  32'(o_full), 0);
    chk("rst_err",   32'(o_err), 0);

    // three back-to-back grants
    i_alloc_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_id", 32'(o_alloc_id), 32'(k));
      tick();
    end
    i_alloc_vld = 1'b0;
    chk("b2b_busy",  32'(o_busy), 32'h0007);
    chk("b2b_cnt",   32'(o_cnt), 3);
    chk("b2b_empty", 32'(o_empty), 0);

    // fill from empty
    do_reset();
    i_alloc_vld = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("fill_rdy", 32'(o_alloc_rdy), 1);
      chk("fill_id",  32'(o_alloc_id), 32'(k));
      tick();
    end
    chk("full_flag", 32'(o_full), 1);
    chk("full_rdy",  32'(o_alloc_rdy), 0);
    chk("full_cnt",  32'(o_cnt), 16);
    tick();  // 17th request, must not be granted
    i_alloc_vld = 1'b0;
    chk("req17_busy", 32'(o_busy), 32'hFFFF);
    chk("req17_cnt",  32'(o_cnt), 16);

    // free id 5 while full
    i_free_vld = 1'b1; i_free_id = 4'd5;
    tick();
    i_free_vld = 1'b0;
    chk("fr5_rdy",  32'(o_alloc_rdy), 1);
    chk("fr5_id",   32'(o_alloc_id), 5);
    chk("fr5_cnt",  32'(o_cnt), 15);
    chk("fr5_busy", 32'(o_busy), 32'hFFDF);
    chk("fr5_full", 32'(o_full), 0);
    i_alloc_vld = 1'b1;
    tick();
    i_alloc_vld = 1'b0;
    chk("refill_full", 32'(o_full), 1);
    chk("refill_cnt",  32'(o_cnt), 16);

    // no bypass: alloc + free while full grants nothing
    i_alloc_vld = 1'b1; i_free_vld = 1'b1; i_free_id = 4'd3;
    chk("nobyp_rdy", 32'(o_alloc_rdy), 0);
    tick();
    i_alloc_vld = 1'b0; i_free_vld = 1'b0;
    chk("nobyp_busy", 32'(o_busy), 32'hFFF7);
    chk("nobyp_cnt",  32'(o_cnt), 15);
    chk("nobyp_id",   32'(o_alloc_id), 3);

    // simultaneous alloc and free with busy=000F
    do_reset();
    i_alloc_vld = 1'b1;
    repeat (4) tick();
    chk("sim_pre_busy", 32'(o_busy), 32'h000F);
    i_free_vld = 1'b1; i_free_id = 4'd1;
    chk("sim_grant_id", 32'(o_alloc_id), 4);
    tick();
    i_alloc_vld = 1'b0; i_free_vld = 1'b0;
    chk("sim_busy", 32'(o_busy), 32'h001D);
    chk("sim_cnt",  32'(o_cnt), 4);
    chk("sim_id",   32'(o_alloc_id), 1);

    // double free of id 9
    i_free_vld = 1'b1; i_free_id = 4'd9;
    tick();
    i_free_vld = 1'b0;
    chk("dfree_err",  32'(o_err), 1);
    chk("dfree_busy", 32'(o_busy), 32'h001D);
    chk("dfree_cnt",  32'(o_cnt), 4);
    tick();
    chk("dfree_sticky", 32'(o_err), 1);

    // reset priority with busy=00FF and err set
    do_reset();
    i_alloc_vld = 1'b1;
    repeat (8) tick();
    i_alloc_vld = 1'b0;
    chk("rp_pre_busy", 32'(o_busy), 32'h00FF);
    i_free_vld = 1'b1; i_free_id = 4'd12;
    tick();
    chk("rp_pre_err", 32'(o_err), 1);
    rst = 1'b1; i_alloc_vld = 1'b1; i_free_vld = 1'b1; i_free_id = 4'd2;
    tick();
    rst = 1'b0; i_alloc_vld = 1'b0; i_free_vld = 1'b0;
    chk("rp_busy",  32'(o_busy), 0);
    chk("rp_cnt",   32'(o_cnt), 0);
    chk("rp_err",   32'(o_err), 0);
    chk("rp_rdy",   32'(o_alloc_rdy), 1);
    chk("rp_id",    32'(o_alloc_id), 0);
    chk("rp_empty", 32'(o_empty), 1);
    chk("rp_full",  32'(o_full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
